// File: rtl/ntt_core_arbiter.sv
// Purpose : round-robin arbiter sharing one NTT / inverse-NTT engine among N_REQ requesters.
// Latency : gnt and eng_start 1 cycle after req in IDLE; done 1 cycle after eng_done; re-grant >= 2 cycles after done.
// Backpressure: req is a held level; one job in flight, others wait in IDLE; WAIT is bounded by a watchdog.
// Ports   : req/req_inv/req_poly per requester in; gnt/done per requester out; res_poly result;
//           busy, sticky timeout_err/err_id; eng_* drive and observe the shared engine.
module ntt_core_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 4096,
  parameter int TO_W    = 13
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      req_inv,
  input  logic [N_REQ*8192-1:0] req_poly,
  input  logic                  abort,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      done,
  output logic [8191:0]         res_poly,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [ID_W-1:0]       err_id,
  output logic                  eng_start,
  output logic                  eng_inv,
  output logic [8191:0]         eng_poly_in,
  input  logic                  eng_done,
  input  logic [8191:0]         eng_poly_out
);

  localparam int PW = 8192;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RELEASE} state_t;

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [PW-1:0]     res_q, res_d;
  logic              terr_q, terr_d;
  logic [ID_W-1:0]   err_id_q, err_id_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;

  logic              found;
  logic [ID_W-1:0]   winner;

  // Search starts just after the last served requester and wraps, so the
  // previous winner is considered last.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found && req[(int'(ptr_q) + k) % N_REQ]) begin
        found  = 1'b1;
        winner = ID_W'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    res_d    = res_q;
    terr_d   = terr_q;
    err_id_d = err_id_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = N_REQ'(1) << winner;
          id_d    = winner;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d = '0;
        if (abort) begin
          gnt_d   = '0;
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + TO_W'(1);
        // Priority: abort, then completion, then watchdog expiry.
        if (abort) begin
          gnt_d   = '0;
          state_d = IDLE;
        end else if (eng_done) begin
          res_d        = eng_poly_out;
          done_d[id_q] = 1'b1;
          gnt_d        = '0;
          ptr_d        = id_q;
          state_d      = RELEASE;
        end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          terr_d   = 1'b1;
          err_id_d = id_q;
          gnt_d    = '0;
          ptr_d    = id_q;
          state_d  = IDLE;
        end
      end
      // Bubble so the requester can drop req after seeing done.
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      done_q   <= '0;
      res_q    <= '0;
      terr_q   <= 1'b0;
      err_id_q <= '0;
      cnt_q    <= '0;
      ptr_q    <= ID_W'(N_REQ - 1);
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      res_q    <= res_d;
      terr_q   <= terr_d;
      err_id_q <= err_id_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
    end
  end

  // Engine inputs follow the registered one-hot grant; zero when nothing granted.
  always_comb begin
    eng_poly_in = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_q[i]) eng_poly_in = eng_poly_in | req_poly[PW*i +: PW];
    end
  end

  assign eng_inv     = |(gnt_q & req_inv);
  assign eng_start   = (state_q == LAUNCH);
  assign busy        = (state_q != IDLE);
  assign gnt         = gnt_q;
  assign done        = done_q;
  assign res_poly    = res_q;
  assign timeout_err = terr_q;
  assign err_id      = err_id_q;

endmodule

// File: tb/tb_ntt_core_arbiter.sv
module tb_ntt_core_arbiter;

  logic               clock = 1'b0;
  logic               reset;
  logic [3:0]         req;
  logic [3:0]         req_inv;
  logic [4*8192-1:0]  req_poly;
  logic               abort;
  logic [3:0]         gnt;
  logic [3:0]         done;
  logic [8191:0]      res_poly;
  logic               busy;
  logic               timeout_err;
  logic [1:0]         err_id;
  logic               eng_start;
  logic               eng_inv;
  logic [8191:0]      eng_poly_in;
  logic               eng_done;
  logic [8191:0]      eng_poly_out;

  int n_chk  = 0;
  int n_fail = 0;
  int onehot_viol = 0;
  logic [63:0] w [4];

  ntt_core_arbiter #(.N_REQ(4), .ID_W(2), .TIMEOUT(16), .TO_W(5)) dut (
    .clock(clock), .reset(reset), .req(req), .req_inv(req_inv), .req_poly(req_poly),
    .abort(abort), .gnt(gnt), .done(done), .res_poly(res_poly), .busy(busy),
    .timeout_err(timeout_err), .err_id(err_id), .eng_start(eng_start), .eng_inv(eng_inv),
    .eng_poly_in(eng_poly_in), .eng_done(eng_done), .eng_poly_out(eng_poly_out)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset === 1'b1 && !$onehot0(gnt)) onehot_viol++;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Full job for requester id: grant, one start, engine returns ~poly, done pulse.
  task automatic run_job(input int id, input bit drop, input bit reraise);
    int k;
    int starts;
    k = 0;
    while (gnt == 4'b0 && k < 8) begin
      tick();
      k++;
    end
    chk("gnt_latency", 64'(k), 64'd1);
    chk("gnt", 64'(gnt), 64'(1) << id);
    chk("eng_start", 64'(eng_start), 64'd1);
    chk("eng_inv", 64'(eng_inv), 64'(req_inv[id]));
    chk("poly_in_lo", eng_poly_in[63:0], w[id]);
    chk("poly_in_hi", eng_poly_in[8191:8128], w[id]);
    starts = int'(eng_start);
    for (int c = 0; c < 8; c++) begin
      tick();
      starts += int'(eng_start);
    end
    chk("one_start", 64'(starts), 64'd1);
    eng_done = 1'b1;
    eng_poly_out = ~eng_poly_in;
    chk("no_early_done", 64'(done), 64'd0);
    tick();
    eng_done = 1'b0;
    chk("done", 64'(done), 64'(1) << id);
    chk("res_lo", res_poly[63:0], ~w[id]);
    chk("res_hi", res_poly[8191:8128], ~w[id]);
    chk("gnt_clr", 64'(gnt), 64'd0);
    chk("busy_release", 64'(busy), 64'd1);
    if (drop) req[id] = 1'b0;
    tick();
    chk("done_1cyc", 64'(done), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);
    if (reraise) req[id] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [3:0] dones;
    w[0] = 64'h0123_4567_89AB_CDEF;
    w[1] = 64'hFEDC_BA98_7654_3210;
    w[2] = 64'h5555_AAAA_3333_CCCC;
    w[3] = 64'h0F0F_0F0F_F0F0_F0F0;
    for (int i = 0; i < 4; i++) req_poly[8192*i +: 8192] = {128{w[i]}};
    reset = 1'b0;
    req = 4'b0;
    req_inv = 4'b0100;
    abort = 1'b0;
    eng_done = 1'b0;
    eng_poly_out = '0;
    repeat (3) tick();
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_terr", 64'(timeout_err), 64'd0);
    chk("rst_err_id", 64'(err_id), 64'd0);
    chk("rst_start", 64'(eng_start), 64'd0);
    chk("rst_res", res_poly[63:0], 64'd0);
    chk("rst_poly_in", eng_poly_in[63:0], 64'd0);
    reset = 1'b1;
    tick();

    // Single request from requester 0, forward mode.
    req = 4'b0001;
    run_job(0, 1'b1, 1'b0);

    // Simultaneous requests straight after reset: 0,1,2,3.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) run_job(i, 1'b1, 1'b0);

    // Fairness between 0 and 2; last served was 3 so 0 goes first.
    req = 4'b0101;
    run_job(0, 1'b1, 1'b1);
    run_job(2, 1'b1, 1'b1);
    run_job(0, 1'b1, 1'b1);
    run_job(2, 1'b1, 1'b0);
    req = 4'b0;
    tick();

    // Timeout: engine silent, expiry on the 17th edge after the grant edge.
    req = 4'b0100;
    tick();
    chk("to_gnt", 64'(gnt), 64'b0100);
    chk("to_inv", 64'(eng_inv), 64'd1);
    dones = 4'b0;
    repeat (16) begin
      tick();
      dones |= done;
    end
    chk("to_not_yet", 64'(timeout_err), 64'd0);
    chk("to_busy_wait", 64'(busy), 64'd1);
    tick();
    dones |= done;
    chk("to_err", 64'(timeout_err), 64'd1);
    chk("to_err_id", 64'(err_id), 64'd2);
    chk("to_gnt_clr", 64'(gnt), 64'd0);
    chk("to_idle", 64'(busy), 64'd0);
    chk("to_no_done", 64'(dones), 64'd0);
    req = 4'b0001;
    run_job(0, 1'b1, 1'b0);
    chk("to_sticky", 64'(timeout_err), 64'd1);
    chk("to_id_sticky", 64'(err_id), 64'd2);

    // Abort colliding with eng_done on requester 1's job.
    req = 4'b0010;
    tick();
    chk("ab_gnt", 64'(gnt), 64'b0010);
    tick();
    tick();
    eng_done = 1'b1;
    abort = 1'b1;
    eng_poly_out = {128{64'hFFFF_0000_FFFF_0000}};
    tick();
    eng_done = 1'b0;
    abort = 1'b0;
    chk("ab_no_done", 64'(done), 64'd0);
    chk("ab_idle", 64'(busy), 64'd0);
    chk("ab_gnt_clr", 64'(gnt), 64'd0);
    chk("ab_res_kept", res_poly[63:0], ~w[0]);
    chk("ab_terr_kept", 64'(timeout_err), 64'd1);
    // Pointer still names requester 0 (last completed), so 1 wins next.
    req = 4'b0011;
    run_job(1, 1'b1, 1'b0);
    run_job(0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a WAIT.
    req = 4'b1000;
    tick();
    tick();
    tick();
    chk("rm_busy_before", 64'(busy), 64'd1);
    #3;
    reset = 1'b0;
    #1;
    chk("rm_gnt", 64'(gnt), 64'd0);
    chk("rm_busy", 64'(busy), 64'd0);
    chk("rm_start", 64'(eng_start), 64'd0);
    chk("rm_terr", 64'(timeout_err), 64'd0);
    chk("rm_err_id", 64'(err_id), 64'd0);
    chk("rm_res", res_poly[63:0], 64'd0);
    req = 4'b0;
    tick();
    reset = 1'b1;
    eng_done = 1'b1;
    eng_poly_out = '1;
    tick();
    eng_done = 1'b0;
    chk("late_done", 64'(done), 64'd0);
    chk("late_res", res_poly[63:0], 64'd0);
    req = 4'b1000;
    run_job(3, 1'b1, 1'b0);

    chk("gnt_onehot", 64'(onehot_viol), 64'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
